outbuf_mem: RTL and testbench

Output buffer sitting directly downstream of the encoding engine. It captures each completed parity result, which is PCK_TREE_XOR_UNITS_NUM × W packets, into a small circular FIFO. It acknowledges the engine and back-pressures it via a registered full flag. It then drains each stored result to the host side one XOR-unit row (W packets) per beat under a valid/ready handshake.

---
 rtl/outbuf_mem.sv | 158 +++++++++++++++
 tb/tb_outbuf_mem.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/outbuf_mem.sv
// outbuf_mem: circular FIFO of DEPTH parity results (M rows x W packets each),
// written whole by the encoding engine and drained to the host one row per beat.
// Latency: write in cycle N -> ack and (if previously empty) row 0 valid in N+1.
// Backpressure: registered full flag rejects engine writes. Host ready stalls the row.
//
// Ports:
//   clk, rstn             clock and asynchronous active-low reset
//   outbuf_rstn           synchronous active-low soft clear, same effect as rstn
//   eng_outbuf_dout_reg   full engine result; row r occupies bits [r*PACKET_LENGTH*W +: PACKET_LENGTH*W]
//   eng_outbuf_wr_req     write request; outbuf_eng_wr_ack pulses one cycle after acceptance
//   outbuf_eng_full       registered, no free entry
//   outbuf_empty          registered, no stored entry
//   outbuf_dout*          current row, valid, row index, last-row marker
//   host_outbuf_rd_rdy    host accepts the current row
//   outbuf_ovf_err        sticky write-while-full flag
// Optional feature macro: OUTBUF_OVERFLOW_CHK_EN enables the overflow detector.
// Without it, outbuf_ovf_err is tied low.
module outbuf_mem #(
  parameter int PACKET_LENGTH          = 32,
  parameter int W                      = 8,
  parameter int PCK_TREE_XOR_UNITS_NUM = 4,
  parameter int DEPTH                  = 4
) (
  input  logic                                      clk,
  input  logic                                      rstn,
  input  logic                                      outbuf_rstn,
  input  logic [PACKET_LENGTH*PCK_TREE_XOR_UNITS_NUM*W-1:0] eng_outbuf_dout_reg,
  input  logic                                      eng_outbuf_wr_req,
  output logic                                      outbuf_eng_wr_ack,
  output logic                                      outbuf_eng_full,
  output logic                                      outbuf_empty,
  output logic [PACKET_LENGTH*W-1:0]                outbuf_dout,
  output logic                                      outbuf_dout_val,
  output logic [$clog2(PCK_TREE_XOR_UNITS_NUM)-1:0] outbuf_dout_row_idx,
  output logic                                      outbuf_dout_last,
  input  logic                                      host_outbuf_rd_rdy,
  output logic                                      outbuf_ovf_err
);

  localparam int M     = PCK_TREE_XOR_UNITS_NUM;
  localparam int ROW_W = PACKET_LENGTH * W;
  localparam int PW    = $clog2(DEPTH);
  localparam int RW    = $clog2(M);
  localparam int CW    = PW + 1;

  localparam logic [RW-1:0] LAST_ROW = RW'(M - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  // Storage is not reset. An entry is only visible once cnt says it is stored.
  logic [M-1:0][ROW_W-1:0] mem_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [RW-1:0] row_cnt_q, row_cnt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          ack_q, ack_d;

  logic wr_acc;
  logic rd_acc;
  logic pop;
  logic dout_val;

  assign wr_acc   = eng_outbuf_wr_req & ~full_q;
  assign dout_val = (cnt_q != '0);
  assign rd_acc   = dout_val & host_outbuf_rd_rdy;
  assign pop      = rd_acc & (row_cnt_q == LAST_ROW);

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    row_cnt_d = row_cnt_q;
    cnt_d     = cnt_q;
    full_d    = full_q;
    empty_d   = empty_q;
    ack_d     = 1'b0;
    if (!outbuf_rstn) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      row_cnt_d = '0;
      cnt_d     = '0;
      full_d    = 1'b0;
      empty_d   = 1'b1;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + PW'(1);
      if (rd_acc) row_cnt_d = pop ? '0 : row_cnt_q + RW'(1);
      if (pop)    rd_ptr_d = rd_ptr_q + PW'(1);
      case ({wr_acc, pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
      // Flags come from the next count so they are ready at the same edge.
      // An entry freed this cycle is therefore seen by the engine only next cycle.
      full_d  = (cnt_d == CNT_FULL);
      empty_d = (cnt_d == '0);
      ack_d   = wr_acc;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      row_cnt_q <= '0;
      cnt_q     <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      ack_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      row_cnt_q <= row_cnt_d;
      cnt_q     <= cnt_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      ack_q     <= ack_d;
    end
  end

  // The entry being read can never be the write target: wr_ptr only equals
  // rd_ptr when the FIFO is empty or full. The read data therefore holds
  // while the host stalls.
  always_ff @(posedge clk) begin
    if (wr_acc & outbuf_rstn) mem_q[wr_ptr_q] <= eng_outbuf_dout_reg;
  end

  assign outbuf_dout         = mem_q[rd_ptr_q][row_cnt_q];
  assign outbuf_dout_val     = dout_val;
  assign outbuf_dout_row_idx = row_cnt_q;
  assign outbuf_dout_last    = dout_val & (row_cnt_q == LAST_ROW);
  assign outbuf_eng_wr_ack   = ack_q;
  assign outbuf_eng_full     = full_q;
  assign outbuf_empty        = empty_q;

`ifdef OUTBUF_OVERFLOW_CHK_EN
  // The engine gates its request with ~full, so a request seen while full
  // is a protocol error. The flag holds until a reset or a soft clear.
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (!outbuf_rstn) ovf_d = 1'b0;
    else if (eng_outbuf_wr_req & full_q) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end

  assign outbuf_ovf_err = ovf_q;
`else
  assign outbuf_ovf_err = 1'b0;
`endif

endmodule

// File: tb/tb_outbuf_mem.sv
// Testbench for outbuf_mem: directed vector table, directed sequences, and a
// randomized run checked against a queue-based reference model.
module tb_outbuf_mem;

  localparam int PL    = 32;
  localparam int W     = 8;
  localparam int M     = 4;
  localparam int DEPTH = 4;
  localparam int ROW_W = PL * W;
  localparam int ENT_W = ROW_W * M;
  localparam int RW    = $clog2(M);

`ifdef OUTBUF_OVERFLOW_CHK_EN
  localparam logic OVF_EN = 1'b1;
`else
  localparam logic OVF_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rstn;
  logic             outbuf_rstn;
  logic [ENT_W-1:0] eng_outbuf_dout_reg;
  logic             eng_outbuf_wr_req;
  logic             outbuf_eng_wr_ack;
  logic             outbuf_eng_full;
  logic             outbuf_empty;
  logic [ROW_W-1:0] outbuf_dout;
  logic             outbuf_dout_val;
  logic [RW-1:0]    outbuf_dout_row_idx;
  logic             outbuf_dout_last;
  logic             host_outbuf_rd_rdy;
  logic             outbuf_ovf_err;

  outbuf_mem #(
    .PACKET_LENGTH(PL), .W(W), .PCK_TREE_XOR_UNITS_NUM(M), .DEPTH(DEPTH)
  ) dut (
    .clk                 (clk),
    .rstn                (rstn),
    .outbuf_rstn         (outbuf_rstn),
    .eng_outbuf_dout_reg (eng_outbuf_dout_reg),
    .eng_outbuf_wr_req   (eng_outbuf_wr_req),
    .outbuf_eng_wr_ack   (outbuf_eng_wr_ack),
    .outbuf_eng_full     (outbuf_eng_full),
    .outbuf_empty        (outbuf_empty),
    .outbuf_dout         (outbuf_dout),
    .outbuf_dout_val     (outbuf_dout_val),
    .outbuf_dout_row_idx (outbuf_dout_row_idx),
    .outbuf_dout_last    (outbuf_dout_last),
    .host_outbuf_rd_rdy  (host_outbuf_rd_rdy),
    .outbuf_ovf_err      (outbuf_ovf_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk_b(input string nm, input logic a, input logic e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, a, e);
    end
  endtask

  task automatic chk_r(input string nm, input logic [RW-1:0] a, input logic [RW-1:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, a, e);
    end
  endtask

  task automatic chk_w(input string nm, input logic [ROW_W-1:0] a, input logic [ROW_W-1:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  // Directed data: every packet of row r of entry "tag" is 0xA0 + r + 0x100*tag.
  function automatic logic [ROW_W-1:0] make_row(input int tag, input int r);
    logic [31:0] pkt;
    pkt = 32'(32'hA0 + r + 256 * tag);
    return {W{pkt}};
  endfunction

  function automatic logic [ENT_W-1:0] make_entry(input int tag);
    logic [ENT_W-1:0] e;
    e = '0;
    for (int r = 0; r < M; r++) e[r*ROW_W +: ROW_W] = make_row(tag, r);
    return e;
  endfunction

  task automatic drive(input logic req, input int tag, input logic rdy, input logic clr);
    eng_outbuf_wr_req   = req;
    eng_outbuf_dout_reg = make_entry(tag);
    host_outbuf_rd_rdy  = rdy;
    outbuf_rstn         = ~clr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One record per cycle: inputs applied in that cycle, outputs observed in it.
  typedef struct {
    logic       req;
    int         tag;
    logic       rdy;
    logic       clr;
    logic       e_ack;
    logic       e_val;
    logic [1:0] e_row;
    logic       e_last;
    logic       e_full;
    logic       e_empty;
    int         e_tag;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic req, input int tag, input logic rdy, input logic clr,
                              input logic ack, input logic val, input int row, input logic last,
                              input logic full, input logic empty, input int etag);
    vec_t v;
    v.req = req; v.tag = tag; v.rdy = rdy; v.clr = clr;
    v.e_ack = ack; v.e_val = val; v.e_row = 2'(row); v.e_last = last;
    v.e_full = full; v.e_empty = empty; v.e_tag = etag;
    tbl.push_back(v);
  endfunction

  // Reference model state
  logic [ENT_W-1:0] mq[$];
  int               mrow;
  logic             m_full, m_empty, m_ack, m_ovf;
  logic             r_req, r_rdy, r_clr, acc;
  logic [ENT_W-1:0] r_dat, tmp;
  vec_t             v;

  initial begin
    // -------- build table --------
    // A: single write, drain with ready held high
    add(1, 1, 1, 0,  0, 0, 0, 0, 0, 1, 0);
    add(0, 0, 1, 0,  1, 1, 0, 0, 0, 0, 1);
    add(0, 0, 1, 0,  0, 1, 1, 0, 0, 0, 1);
    add(0, 0, 1, 0,  0, 1, 2, 0, 0, 0, 1);
    add(0, 0, 1, 0,  0, 1, 3, 1, 0, 0, 1);
    add(0, 0, 1, 0,  0, 0, 0, 0, 0, 1, 0);
    // B: ready toggling 1,0,1,0 during a drain
    add(1, 2, 0, 0,  0, 0, 0, 0, 0, 1, 0);
    add(0, 0, 1, 0,  1, 1, 0, 0, 0, 0, 2);
    add(0, 0, 0, 0,  0, 1, 1, 0, 0, 0, 2);
    add(0, 0, 1, 0,  0, 1, 1, 0, 0, 0, 2);
    add(0, 0, 0, 0,  0, 1, 2, 0, 0, 0, 2);
    add(0, 0, 1, 0,  0, 1, 2, 0, 0, 0, 2);
    add(0, 0, 0, 0,  0, 1, 3, 1, 0, 0, 2);
    add(0, 0, 1, 0,  0, 1, 3, 1, 0, 0, 2);
    add(0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 0);
    // C: soft clear after 2 of 4 rows with 2 entries stored, then a fresh write
    add(1, 3, 0, 0,  0, 0, 0, 0, 0, 1, 0);
    add(1, 4, 0, 0,  1, 1, 0, 0, 0, 0, 3);
    add(0, 0, 1, 0,  1, 1, 0, 0, 0, 0, 3);
    add(0, 0, 1, 0,  0, 1, 1, 0, 0, 0, 3);
    add(0, 0, 0, 1,  0, 1, 2, 0, 0, 0, 3);
    add(0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 0);
    add(1, 5, 0, 0,  0, 0, 0, 0, 0, 1, 0);
    add(0, 0, 1, 0,  1, 1, 0, 0, 0, 0, 5);
    add(0, 0, 1, 0,  0, 1, 1, 0, 0, 0, 5);
    add(0, 0, 1, 0,  0, 1, 2, 0, 0, 0, 5);
    add(0, 0, 1, 0,  0, 1, 3, 1, 0, 0, 5);
    add(0, 0, 1, 0,  0, 0, 0, 0, 0, 1, 0);
    // soft clear coincident with a write: the write is lost, no ack
    add(1, 6, 0, 1,  0, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 0);
    // D: fill to full, 5th request held across the pop, pointer wraps 3->0
    for (int t = 1; t <= 4; t++) add(1, t, 0, 0, t > 1, t > 1, 0, 0, 0, t == 1, 1);
    add(1, 5, 0, 0,  1, 1, 0, 0, 1, 0, 1);
    for (int r = 0; r < M; r++) add(1, 5, 1, 0, 0, 1, r, r == M - 1, 1, 0, 1);
    add(1, 5, 1, 0,  0, 1, 0, 0, 0, 0, 2);
    add(0, 0, 1, 0,  1, 1, 1, 0, 1, 0, 2);
    for (int k = 2; k < 16; k++) add(0, 0, 1, 0, 0, 1, k % 4, (k % 4) == 3, (k / 4) == 0, 0, 2 + k / 4);
    add(0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 0);

    // -------- reset state --------
    rstn = 1'b0;
    drive(0, 0, 0, 0);
    @(negedge clk);
    chk_b("rst ack",   outbuf_eng_wr_ack, 1'b0);
    chk_b("rst val",   outbuf_dout_val,   1'b0);
    chk_b("rst full",  outbuf_eng_full,   1'b0);
    chk_b("rst empty", outbuf_empty,      1'b1);
    chk_b("rst last",  outbuf_dout_last,  1'b0);
    chk_b("rst ovf",   outbuf_ovf_err,    1'b0);
    chk_r("rst row",   outbuf_dout_row_idx, '0);
    @(posedge clk);
    #1;
    rstn = 1'b1;

    // -------- apply table --------
    foreach (tbl[i]) begin
      v = tbl[i];
      drive(v.req, v.tag, v.rdy, v.clr);
      @(negedge clk);
      chk_b($sformatf("vec%0d ack", i),   outbuf_eng_wr_ack, v.e_ack);
      chk_b($sformatf("vec%0d val", i),   outbuf_dout_val,   v.e_val);
      chk_r($sformatf("vec%0d row", i),   outbuf_dout_row_idx, v.e_row);
      chk_b($sformatf("vec%0d last", i),  outbuf_dout_last,  v.e_last);
      chk_b($sformatf("vec%0d full", i),  outbuf_eng_full,   v.e_full);
      chk_b($sformatf("vec%0d empty", i), outbuf_empty,      v.e_empty);
      if (v.e_val) chk_w($sformatf("vec%0d dout", i), outbuf_dout, make_row(v.e_tag, int'(v.e_row)));
      tick();
    end

    // -------- overflow flag --------
    drive(0, 0, 0, 1);
    tick();
    drive(0, 0, 0, 0);
    @(negedge clk);
    chk_b("ovf cleared", outbuf_ovf_err, 1'b0);
    tick();
    for (int t = 1; t <= 4; t++) begin
      drive(1, t, 0, 0);
      tick();
    end
    drive(1, 5, 0, 0);
    @(negedge clk);
    chk_b("ovf full", outbuf_eng_full, 1'b1);
    chk_b("ovf not yet", outbuf_ovf_err, 1'b0);
    tick();
    drive(0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk_b($sformatf("ovf sticky%0d", k), outbuf_ovf_err, OVF_EN);
      tick();
    end
    drive(0, 0, 0, 1);
    tick();
    drive(0, 0, 0, 0);
    @(negedge clk);
    chk_b("ovf after clr", outbuf_ovf_err, 1'b0);
    chk_b("full after clr", outbuf_eng_full, 1'b0);
    tick();

    // -------- hard reset during a write --------
    drive(1, 7, 1, 0);
    #2;
    rstn = 1'b0;
    @(negedge clk);
    chk_b("arst val", outbuf_dout_val, 1'b0);
    chk_b("arst empty", outbuf_empty, 1'b1);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    drive(0, 0, 1, 0);
    @(negedge clk);
    chk_b("arst no ack", outbuf_eng_wr_ack, 1'b0);
    chk_b("arst no val", outbuf_dout_val, 1'b0);
    tick();

    // -------- randomized run against reference model --------
    mq.delete();
    mrow = 0; m_full = 1'b0; m_empty = 1'b1; m_ack = 1'b0; m_ovf = 1'b0;
    for (int c = 0; c < 800; c++) begin
      r_req = ($urandom_range(0, 9) < 6);
      r_rdy = ($urandom_range(0, 9) < ((c < 400) ? 3 : 7));
      r_clr = ($urandom_range(0, 59) == 0);
      for (int k = 0; k < ENT_W / 32; k++) r_dat[k*32 +: 32] = $urandom;
      eng_outbuf_wr_req   = r_req;
      eng_outbuf_dout_reg = r_dat;
      host_outbuf_rd_rdy  = r_rdy;
      outbuf_rstn         = ~r_clr;
      @(negedge clk);
      chk_b("rnd val", outbuf_dout_val, mq.size() != 0);
      chk_b("rnd full", outbuf_eng_full, m_full);
      chk_b("rnd empty", outbuf_empty, m_empty);
      chk_b("rnd ack", outbuf_eng_wr_ack, m_ack);
      chk_b("rnd ovf", outbuf_ovf_err, m_ovf);
      if (mq.size() != 0) begin
        tmp = mq[0];
        chk_r("rnd row", outbuf_dout_row_idx, RW'(mrow));
        chk_b("rnd last", outbuf_dout_last, mrow == M - 1);
        chk_w("rnd dout", outbuf_dout, tmp[mrow*ROW_W +: ROW_W]);
      end
      // model update for the coming edge
      if (r_clr) begin
        mq.delete();
        mrow = 0; m_full = 1'b0; m_empty = 1'b1; m_ack = 1'b0; m_ovf = 1'b0;
      end else begin
        acc = r_req && !m_full;
        if (OVF_EN && r_req && m_full) m_ovf = 1'b1;
        if (mq.size() != 0 && r_rdy) begin
          if (mrow == M - 1) begin
            void'(mq.pop_front());
            mrow = 0;
          end else begin
            mrow++;
          end
        end
        if (acc) mq.push_back(r_dat);
        m_ack   = acc;
        m_full  = (mq.size() == DEPTH);
        m_empty = (mq.size() == 0);
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
